// File: rtl/memory_responder_if.sv
// Request/response bundle between the decode stage (master) and the memory
// responder (slave); clock and reset travel as plain ports.
interface memory_responder_if;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_width;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        req_ack;
    logic [31:0] read_data;
    logic        bus_error;
    logic        busy;

    modport master (
        output req_valid, req_read, req_write, req_width, req_address, req_write_data,
        input  req_ack, read_data, bus_error, busy
    );

    modport slave (
        input  req_valid, req_read, req_write, req_width, req_address, req_write_data,
        output req_ack, read_data, bus_error, busy
    );
endinterface

// File: rtl/memory_responder.sv
// Memory-access slave: word-organised RAM, big-endian byte/word/long lanes, programmable
// wait states. Define MEMORY_RESPONDER_ALIGN_CHECK_EN to reject misaligned long/word cycles.
module memory_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic               clock,
    input  logic               reset,
    memory_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  width_q, width_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        berr_q, berr_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem_word;
    logic [3:0]       be;
    logic [31:0]      wlane;
    logic [31:0]      rlane;
    logic             align_err;
    logic             access_err;
    logic             ram_we;

`ifdef MEMORY_RESPONDER_ALIGN_CHECK_EN
    assign align_err = ((width_q == 2'b00) && (addr_q[1:0] != 2'b00)) ||
                       ((width_q == 2'b01) && addr_q[0]);
`else
    assign align_err = 1'b0;
`endif

    // Exactly one of read/write must be set; the range test uses the full word index.
    assign access_err = (width_q == 2'b11) || (rd_q == wr_q) ||
                        ({2'b00, addr_q[31:2]} >= 32'(DEPTH)) || align_err;

    assign idx      = addr_q[IDX_W+1:2];
    assign mem_word = mem[idx];

    // Long ignores address[1:0] and word ignores address[0], so alignment falls out of the lane decode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        be    = 4'b0000;
        wlane = 32'h0;
        rlane = 32'h0;
        unique case (width_q)
            2'b00: begin
                be    = 4'b1111;
                wlane = wdata_q;
                rlane = mem_word;
            end
            2'b01: begin
                wlane = {2{wdata_q[15:0]}};
                if (addr_q[1]) begin
                    be    = 4'b0011;
                    rlane = {16'h0, mem_word[15:0]};
                end else begin
                    be    = 4'b1100;
                    rlane = {16'h0, mem_word[31:16]};
                end
            end
            2'b10: begin
                wlane = {4{wdata_q[7:0]}};
                unique case (addr_q[1:0])
                    2'b00: begin be = 4'b1000; rlane = {24'h0, mem_word[31:24]}; end
                    2'b01: begin be = 4'b0100; rlane = {24'h0, mem_word[23:16]}; end
                    2'b10: begin be = 4'b0010; rlane = {24'h0, mem_word[15:8]};  end
                    default: begin be = 4'b0001; rlane = {24'h0, mem_word[7:0]}; end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        berr_d  = 1'b0;
        rdata_d = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    rd_d    = bus.req_read;
                    wr_d    = bus.req_write;
                    width_d = bus.req_width;
                    addr_d  = bus.req_address;
                    wdata_d = bus.req_write_data;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                ack_d   = 1'b1;
                berr_d  = access_err;
                rdata_d = (access_err || !rd_q) ? 32'h0 : rlane;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            width_q <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ack_q   <= 1'b0;
            berr_q  <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            berr_q  <= berr_d;
            rdata_q <= rdata_d;
        end
    end

    assign ram_we = (state_q == S_ACCESS) && wr_q && !access_err && !reset;

    // NOTE: the RAM array is deliberately not reset; contents survive reset and map onto block RAM.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.bus_error = berr_q;
    assign bus.read_data = rdata_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: three instances (0, 1 and 4 wait states) share
// one stimulus bus; only the selected instance sees req_valid and is monitored.
module tb_memory_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_read, req_write;
    logic [1:0]  req_width;
    logic [31:0] req_address, req_write_data;
    int          sel;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    memory_responder_if if_ws0 ();
    memory_responder_if if_ws1 ();
    memory_responder_if if_ws4 ();

    assign if_ws0.req_valid = req_valid && (sel == 0);
    assign if_ws1.req_valid = req_valid && (sel == 1);
    assign if_ws4.req_valid = req_valid && (sel == 2);
    assign if_ws0.req_read = req_read;  assign if_ws1.req_read = req_read;  assign if_ws4.req_read = req_read;
    assign if_ws0.req_write = req_write; assign if_ws1.req_write = req_write; assign if_ws4.req_write = req_write;
    assign if_ws0.req_width = req_width; assign if_ws1.req_width = req_width; assign if_ws4.req_width = req_width;
    assign if_ws0.req_address = req_address; assign if_ws1.req_address = req_address; assign if_ws4.req_address = req_address;
    assign if_ws0.req_write_data = req_write_data; assign if_ws1.req_write_data = req_write_data; assign if_ws4.req_write_data = req_write_data;

    memory_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (.clock(clock), .reset(reset), .bus(if_ws0));
    memory_responder #(.DEPTH(1024), .WAIT_STATES(1)) u_ws1 (.clock(clock), .reset(reset), .bus(if_ws1));
    memory_responder #(.DEPTH(1024), .WAIT_STATES(4)) u_ws4 (.clock(clock), .reset(reset), .bus(if_ws4));

    logic        m_ack, m_berr, m_busy;
    logic [31:0] m_rdata;

    always_comb begin
        m_ack = if_ws1.req_ack; m_berr = if_ws1.bus_error; m_busy = if_ws1.busy; m_rdata = if_ws1.read_data;
        if (sel == 0) begin
            m_ack = if_ws0.req_ack; m_berr = if_ws0.bus_error; m_busy = if_ws0.busy; m_rdata = if_ws0.read_data;
        end else if (sel == 2) begin
            m_ack = if_ws4.req_ack; m_berr = if_ws4.bus_error; m_busy = if_ws4.busy; m_rdata = if_ws4.read_data;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int s);
        case (s)
            0:       return 0;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    // Monitor: every acknowledge pops one expected response.
    always @(negedge clock) begin
        if (m_ack) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with rdata %h, expected no ack", m_rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_rdata"}, m_rdata, e.rdata);
                check({e.name, "_berr"}, 32'(m_berr), 32'(e.berr));
            end
        end
    end

    task automatic do_req(input string name, input logic rd, input logic wr, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_be, output int ack_cyc);
        exp_t e;
        int   edges;
        e.name = name; e.rdata = exp_rd; e.berr = exp_be;
        sb_q.push_back(e);
        req_read = rd; req_write = wr; req_width = w; req_address = a; req_write_data = wd;
        req_valid = 1'b1;
        @(posedge clock); #1;
        edges = 1;
        check({name, "_busy"}, 32'(m_busy), 32'd1);
        while (!m_ack && edges < 40) begin
            @(posedge clock); #1;
            edges++;
        end
        check({name, "_latency"}, 32'(edges), 32'(ws_of(sel) + 2));
        ack_cyc = cyc;
        req_valid = 1'b0;
        @(posedge clock); #1;
        check({name, "_ack_pulse"}, 32'(m_ack), 32'd0);
        check({name, "_rdata_clr"}, m_rdata | 32'(m_berr), 32'd0);
    endtask

    int c0, c1, c2;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_width = 2'b00;
        req_address = 32'h0; req_write_data = 32'h0;
        sel = 1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_ack",   32'(m_ack),  32'd0);
        check("rst_busy",  32'(m_busy), 32'd0);
        check("rst_berr",  32'(m_berr), 32'd0);
        check("rst_rdata", m_rdata,     32'h0);

        // Long, byte and word lanes with one wait state.
        do_req("wr_l10",  0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0,        0, c0);
        do_req("rd_l10",  1, 0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF, 0, c0);
        do_req("wr_l20",  0, 1, 2'b00, 32'h20, 32'h11223344, 32'h0,        0, c0);
        do_req("wr_b22",  0, 1, 2'b10, 32'h22, 32'h000000AA, 32'h0,        0, c0);
        do_req("rd_l20a", 1, 0, 2'b00, 32'h20, 32'h0,        32'h1122AA44, 0, c0);
        do_req("rd_b21",  1, 0, 2'b10, 32'h21, 32'h0,        32'h00000022, 0, c0);
        do_req("rd_b20",  1, 0, 2'b10, 32'h20, 32'h0,        32'h00000011, 0, c0);
        do_req("rd_b23",  1, 0, 2'b10, 32'h23, 32'h0,        32'h00000044, 0, c0);
        do_req("rd_w20",  1, 0, 2'b01, 32'h20, 32'h0,        32'h00001122, 0, c0);
        do_req("rd_w22",  1, 0, 2'b01, 32'h22, 32'h0,        32'h0000AA44, 0, c0);
        do_req("wr_w20",  0, 1, 2'b01, 32'h20, 32'h0000BEEF, 32'h0,        0, c0);
        do_req("rd_l20b", 1, 0, 2'b00, 32'h20, 32'h0,        32'hBEEFAA44, 0, c0);
        do_req("wr_w22",  0, 1, 2'b01, 32'h22, 32'hFFFF1234, 32'h0,        0, c0);
        do_req("wr_b23",  0, 1, 2'b10, 32'h23, 32'hABCDEF77, 32'h0,        0, c0);
        do_req("rd_l20c", 1, 0, 2'b00, 32'h20, 32'h0,        32'hBEEF1277, 0, c0);

        // Rejected accesses must leave 0x20 untouched.
        do_req("err_w11_rd", 1, 0, 2'b11, 32'h20,       32'h0,        32'h0, 1, c0);
        do_req("err_w11_wr", 0, 1, 2'b11, 32'h20,       32'h0,        32'h0, 1, c0);
        do_req("err_rdwr",   1, 1, 2'b00, 32'h20,       32'h0,        32'h0, 1, c0);
        do_req("err_none",   0, 0, 2'b00, 32'h20,       32'h0,        32'h0, 1, c0);
        do_req("err_wr_top", 0, 1, 2'b00, 32'h1000,     32'hFFFFFFFF, 32'h0, 1, c0);
        do_req("err_rd_top", 1, 0, 2'b00, 32'h1000,     32'h0,        32'h0, 1, c0);
        do_req("err_alias",  0, 1, 2'b00, 32'h80000020, 32'h0,        32'h0, 1, c0);
        do_req("wr_last",    0, 1, 2'b00, 32'hFFC,      32'h0BADF00D, 32'h0, 0, c0);
        do_req("rd_last",    1, 0, 2'b00, 32'hFFC,      32'h0,        32'h0BADF00D, 0, c0);
        do_req("rd_l20d",    1, 0, 2'b00, 32'h20,       32'h0,        32'hBEEF1277, 0, c0);

`ifdef MEMORY_RESPONDER_ALIGN_CHECK_EN
        do_req("al_rd_l21", 1, 0, 2'b00, 32'h21, 32'h0,        32'h0,        1, c0);
        do_req("al_rd_w23", 1, 0, 2'b01, 32'h23, 32'h0,        32'h0,        1, c0);
        do_req("al_wr_w21", 0, 1, 2'b01, 32'h21, 32'h00005555, 32'h0,        1, c0);
        do_req("al_rd_l20", 1, 0, 2'b00, 32'h20, 32'h0,        32'hBEEF1277, 0, c0);
`else
        do_req("al_rd_l21", 1, 0, 2'b00, 32'h21, 32'h0,        32'hBEEF1277, 0, c0);
        do_req("al_rd_w23", 1, 0, 2'b01, 32'h23, 32'h0,        32'h00001277, 0, c0);
        do_req("al_wr_w21", 0, 1, 2'b01, 32'h21, 32'h00005555, 32'h0,        0, c0);
        do_req("al_rd_l20", 1, 0, 2'b00, 32'h20, 32'h0,        32'h55551277, 0, c0);
`endif

        // Four wait states: reset while waiting abandons the write.
        sel = 2;
        do_req("ws4_wr30", 0, 1, 2'b00, 32'h30, 32'h12345678, 32'h0, 0, c0);
        req_read = 1'b0; req_write = 1'b1; req_width = 2'b00;
        req_address = 32'h30; req_write_data = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_ack",  32'(m_ack),  32'd0);
        repeat (8) @(posedge clock);
        #1;
        do_req("ws4_rd30", 1, 0, 2'b00, 32'h30, 32'h0, 32'h12345678, 0, c0);

        // Zero wait states: back-to-back requests complete every three cycles.
        sel = 0;
        do_req("b2b_wr40", 0, 1, 2'b00, 32'h40, 32'h01020304, 32'h0,        0, c0);
        do_req("b2b_rd40", 1, 0, 2'b00, 32'h40, 32'h0,        32'h01020304, 0, c1);
        do_req("b2b_rd41", 1, 0, 2'b10, 32'h41, 32'h0,        32'h00000002, 0, c2);
        check("b2b_gap1", 32'(c1 - c0), 32'd3);
        check("b2b_gap2", 32'(c2 - c1), 32'd3);

        repeat (5) @(posedge clock);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Slave end of the pipeline memory-access interface. Services the load/store requests raised by the decode stage: memory access cycle, read/write strobes and cycle width.
- Contains a word-organised internal RAM.
- Performs big-endian byte, word or long accesses with a programmable number of wait states.
- Returns a one-cycle acknowledge with right-justified read data, or a bus error.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal RAM; valid byte addresses are 0 to DEPTH*4-1.
- WAIT_STATES, 1, extra idle cycles inserted between request capture and RAM access; range 0 to 15.

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; held high by the requester until req_ack.
- req_read  input  1  read request.
- req_write  input  1  write request.
- req_width  input  2  cycle width: 2'b00 long (32-bit), 2'b01 word (16-bit), 2'b10 byte, 2'b11 illegal.
- req_address  input  32  byte address.
- req_write_data  input  32  write data, right-justified.
- req_ack  output  1  one-cycle completion pulse.
- read_data  output  32  read result, right-justified and zero-extended; valid only while req_ack is high.
- bus_error  output  1  qualifies req_ack; access was rejected.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - req_ack, bus_error and busy go to 0; read_data goes to 32'h0.
  - RAM contents are not cleared.
  - Reset asserted mid-transaction abandons it; no ack is issued.
  - A write is lost if reset arrives before its ACCESS edge.
- State machine:
  - IDLE: on req_valid=1, capture read, write, width, address and write data, and load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT: decrement the counter; go to ACCESS when it reaches 1.
  - ACCESS: perform the RAM read or write using the captured values; go to DONE.
  - DONE: req_ack=1 for exactly this cycle, with read_data and bus_error valid; go to IDLE.
- Latency and throughput:
  - req_ack is high in the cycle WAIT_STATES+2 rising edges after the capture edge.
  - req_valid is ignored while busy and during the DONE cycle; the requester drops it on seeing req_ack.
  - A new request is accepted in the first IDLE cycle after DONE, giving one transaction per WAIT_STATES+3 cycles.
- Byte lanes (big-endian):
  - Long: address[1:0] must be 0; the full word is used.
  - Word: address[0] must be 0. address[1]=0 selects bits [31:16]; address[1]=1 selects [15:0].
  - Byte: address[1:0]=0,1,2,3 selects [31:24], [23:16], [15:8], [7:0].
- Reads return the selected lane in the low bits, with upper bits zero.
- Writes take req_write_data low bits into the selected lane only; other lanes are preserved.
- Bus error conditions (req_ack with bus_error=1, read_data=0, RAM unchanged):
  - req_width=2'b11.
  - read and write both 1.
  - read and write both 0.
  - word index address[31:2] >= DEPTH.
- read_data returns to 0 and bus_error to 0 in the cycle after DONE.

Optional Feature:
- Macro: MEMORY_RESPONDER_ALIGN_CHECK_EN.
- Defined: a long access with address[1:0]!=0, or a word access with address[0]=1, completes with bus_error=1, no RAM write and read_data=0.
- Undefined: offending low address bits are ignored. Long uses address[1:0]=0; word uses address[0]=0. The access proceeds normally with no error.

Test Plan:
- Long write then read, WAIT_STATES=1: write 32'hDEADBEEF to 0x10 -> req_ack on the 3rd edge after capture, bus_error=0. Read 0x10 -> read_data=32'hDEADBEEF.
- Byte lanes: long-write 32'h11223344 to 0x20, byte-write 8'hAA to 0x22 -> long read of 0x20 gives 32'h1122AA44. Byte read of 0x21 gives 32'h00000022.
- Word lanes: word read of 0x20 -> 32'h00001122; 0x22 -> 32'h0000AA44. Word-write 16'hBEEF to 0x20 -> long read gives 32'hBEEFAA44.
- Errors: req_width=2'b11; read and write both high; address DEPTH*4 -> each acked with bus_error=1 and read_data=0, and RAM is unchanged.
- Alignment: long read of 0x21 -> with the macro, bus_error=1; without it, returns the word at 0x20.
- Reset in WAIT with WAIT_STATES=4 during a write to 0x30 -> no req_ack, busy=0 next cycle, and the word at 0x30 is unchanged on a later read. Back-to-back requests with WAIT_STATES=0 -> req_ack every 3 cycles.
